// File: rtl/mi_pkg.sv
// Shared types and defaults for the modular-inverse stream controller and its
// word serialiser.
package mi_pkg;

   localparam int MI_K       = 128;
   localparam int MI_N       = 32;
   localparam int MI_TIMEOUT = 2**20;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      START   = 3'd1,
      FEED    = 3'd2,
      WAIT    = 3'd3,
      COLLECT = 3'd4
   } mi_state_t;

   // $clog2(1) is 0, which would leave a zero-width word counter.
   function automatic int clog2_safe(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/mi_word_serdes.sv
// Holds the latched operands and the result register. It presents operand word
// idx during FEED and writes the incoming result word into slot idx.
module mi_word_serdes
   import mi_pkg::*;
#(
   parameter int K = MI_K,
   parameter int N = MI_N,
   parameter int W = clog2_safe(N)
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           load,
   input  logic [K*N-1:0] a_full,
   input  logic [K*N-1:0] p_full,
   input  logic [W-1:0]   idx,
   input  logic           feed_en,
   input  logic           wr_en,
   input  logic [K-1:0]   wr_word,
   output logic [K-1:0]   a_word,
   output logic [K-1:0]   p_word,
   output logic [K*N-1:0] result
);

   logic [K*N-1:0] a_lat;
   logic [K*N-1:0] p_lat;

   always_ff @(posedge clk) begin
      if (rst) begin
         a_lat  <= '0;
         p_lat  <= '0;
         result <= '0;
      end else begin
         if (load) begin
            a_lat <= a_full;
            p_lat <= p_full;
         end
         if (wr_en) begin
            for (int w = 0; w < N; w++) begin
               if (idx == W'(w)) result[w*K +: K] <= wr_word;
            end
         end
      end
   end

   // Word outputs are forced to zero outside FEED so the core sees a quiet bus.
   always_comb begin
      a_word = '0;
      p_word = '0;
      if (feed_en) begin
         for (int w = 0; w < N; w++) begin
            if (idx == W'(w)) begin
               a_word = a_lat[w*K +: K];
               p_word = p_lat[w*K +: K];
            end
         end
      end
   end

endmodule

// File: rtl/mi_stream_ctrl.sv
// Sequencer around the modular-inverse core: latches full-width operands, pulses
// mi_start, streams words LSW first, then reassembles the result or times out.
module mi_stream_ctrl
   import mi_pkg::*;
#(
   parameter int K       = MI_K,
   parameter int N       = MI_N,
   parameter int TIMEOUT = MI_TIMEOUT
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           start_i,
   input  logic [K*N-1:0] a_i,
   input  logic [K*N-1:0] p_i,
   output logic           ready_o,
   output logic           busy_o,
   output logic [K*N-1:0] result_o,
   output logic           done_o,
   output logic           error_o,
   output logic           mi_start_o,
   output logic [K-1:0]   a_o,
   output logic [K-1:0]   p_o,
   output logic           valid_in_o,
   input  logic [K-1:0]   r_i,
   input  logic           valid_out_i
);

   localparam int WW = clog2_safe(N);
   localparam int TW = $clog2(TIMEOUT) + 1;
   localparam logic [WW-1:0] LAST_WORD = WW'(N - 1);
   localparam logic [TW-1:0] LAST_WAIT = TW'(TIMEOUT - 1);

   mi_state_t     state;
   mi_state_t     state_next;
   logic [WW-1:0] word_idx;
   logic [TW-1:0] wait_cnt;
   logic          done_q;
   logic          accept;
   logic          capture;
   logic          feed_last;
   logic          collect_last;
   logic          timed_out;

   assign accept       = (state == IDLE) && start_i;
   assign capture      = ((state == WAIT) || (state == COLLECT)) && valid_out_i;
   assign feed_last    = (state == FEED) && (word_idx == LAST_WORD);
   // word_idx is 0 in WAIT, so this also covers the single-word case there.
   assign collect_last = capture && (word_idx == LAST_WORD);
   assign timed_out    = (state == WAIT) && !valid_out_i && (wait_cnt == LAST_WAIT);

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      unique case (state)
         IDLE:    if (start_i) state_next = START;
         START:   state_next = FEED;
         FEED:    if (feed_last) state_next = WAIT;
         WAIT: begin
            if (valid_out_i)    state_next = collect_last ? IDLE : COLLECT;
            else if (timed_out) state_next = IDLE;
         end
         COLLECT: if (collect_last) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      ready_o    = 1'b0;
      busy_o     = 1'b1;
      mi_start_o = 1'b0;
      valid_in_o = 1'b0;
      error_o    = 1'b0;
      unique case (state)
         IDLE: begin
            ready_o = 1'b1;
            busy_o  = 1'b0;
         end
         START:   mi_start_o = 1'b1;
         FEED:    valid_in_o = 1'b1;
         WAIT:    error_o    = timed_out;
         default: ;
      endcase
   end

   assign done_o = done_q;

   // One index serves both directions; it holds through COLLECT gaps and is
   // parked at zero everywhere else.
   always_ff @(posedge clk) begin
      if (rst) begin
         word_idx <= '0;
         wait_cnt <= '0;
         done_q   <= 1'b0;
      end else begin
         done_q <= collect_last;
         if ((state == FEED) || capture)
            word_idx <= (word_idx == LAST_WORD) ? '0 : word_idx + 1'b1;
         else if (state != COLLECT)
            word_idx <= '0;
         wait_cnt <= (state == WAIT) ? wait_cnt + 1'b1 : '0;
      end
   end

   mi_word_serdes #(
      .K (K),
      .N (N),
      .W (WW)
   ) u_serdes (
      .clk     (clk),
      .rst     (rst),
      .load    (accept),
      .a_full  (a_i),
      .p_full  (p_i),
      .idx     (word_idx),
      .feed_en (state == FEED),
      .wr_en   (capture),
      .wr_word (r_i),
      .a_word  (a_o),
      .p_word  (p_o),
      .result  (result_o)
   );

endmodule

// File: tb/tb_mi_stream_ctrl.sv
// Bench for mi_stream_ctrl (K=8, N=4, TIMEOUT=16) with a behavioural stub core
// whose answer delay, mid-stream gap and trailing extra word are configurable.
module tb_mi_stream_ctrl;

   localparam int K       = 8;
   localparam int N       = 4;
   localparam int TIMEOUT = 16;
   localparam int W       = K * N;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start_i = 1'b0;
   logic [W-1:0] a_i = '0;
   logic [W-1:0] p_i = '0;
   logic         ready_o, busy_o, done_o, error_o, mi_start_o, valid_in_o;
   logic [W-1:0] result_o;
   logic [K-1:0] a_o, p_o;
   logic [K-1:0] r_i = '0;
   logic         valid_out_i = 1'b0;

   mi_stream_ctrl #(.K(K), .N(N), .TIMEOUT(TIMEOUT)) dut (
      .clk         (clk),
      .rst         (rst),
      .start_i     (start_i),
      .a_i         (a_i),
      .p_i         (p_i),
      .ready_o     (ready_o),
      .busy_o      (busy_o),
      .result_o    (result_o),
      .done_o      (done_o),
      .error_o     (error_o),
      .mi_start_o  (mi_start_o),
      .a_o         (a_o),
      .p_o         (p_o),
      .valid_in_o  (valid_in_o),
      .r_i         (r_i),
      .valid_out_i (valid_out_i)
   );

   always #5 clk = ~clk;

   logic [W-1:0]   exp_q[$];
   logic [2*K-1:0] feed_q[$];
   int n_checks = 0, n_pass = 0;
   int cyc = 0, mfed = 0, last_feed_cyc = 0;
   int n_start = 0, n_done = 0, n_error = 0, n_vin = 0;

   logic [K-1:0] resp [N];
   int resp_delay = 5, gap_cfg = 0;
   bit answer = 1'b1, extra = 1'b0;
   int sfed = 0, cd = 0, e = 0, gap_left = 0;
   bit emitting = 1'b0, extra_pending = 1'b0;

   task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [W-1:0] expected_result();
      logic [W-1:0] r;
      for (int i = 0; i < N; i++) r[K*i +: K] = resp[i];
      return r;
   endfunction

   task automatic set_resp(input logic [K-1:0] r0, input logic [K-1:0] r1,
                           input logic [K-1:0] r2, input logic [K-1:0] r3);
      resp[0] = r0; resp[1] = r1; resp[2] = r2; resp[3] = r3;
   endtask

   task automatic push_job(input logic [W-1:0] a, input logic [W-1:0] p, input bit want_result);
      for (int i = 0; i < N; i++) feed_q.push_back({a[K*i +: K], p[K*i +: K]});
      if (want_result) exp_q.push_back(expected_result());
   endtask

   task automatic start_job(input logic [W-1:0] a, input logic [W-1:0] p, input bit want_result);
      int guard = 0;
      while (!ready_o && guard < 200) begin tick(); guard++; end
      check("ready_before_start", W'(ready_o), 1);
      start_i = 1'b1; a_i = a; p_i = p;
      push_job(a, p, want_result);
      tick();
      start_i = 1'b0;
   endtask

   task automatic wait_count(input bit for_error, input int target, input int budget);
      int t = 0;
      int seen;
      seen = for_error ? n_error : n_done;
      while (seen < target && t < budget) begin
         tick(); t++;
         seen = for_error ? n_error : n_done;
      end
      if (for_error) check("error_seen", W'(int'(seen >= target)), 1);
      else           check("done_seen",  W'(int'(seen >= target)), 1);
   endtask

   task automatic wait_done_level(input int budget);
      int t = 0;
      while (!done_o && t < budget) begin tick(); t++; end
      check("done_level", W'(done_o), 1);
   endtask

   // Monitor / scoreboard: samples DUT outputs on the falling edge.
   initial begin
      forever begin
         @(negedge clk);
         cyc++;
         if (mi_start_o) n_start++;
         if (valid_in_o) begin
            n_vin++;
            check("feed_pending", W'(int'(feed_q.size() > 0)), 1);
            if (feed_q.size() > 0) check("feed_word", W'({a_o, p_o}), W'(feed_q.pop_front()));
            mfed++;
            if (mfed == N) begin mfed = 0; last_feed_cyc = cyc; end
         end
         if (done_o) begin
            n_done++;
            check("done_latency", cyc - last_feed_cyc, resp_delay + N + gap_cfg);
            check("result_pending", W'(int'(exp_q.size() > 0)), 1);
            if (exp_q.size() > 0) check("result", result_o, exp_q.pop_front());
         end
         if (error_o) begin
            n_error++;
            check("error_cycle", cyc - last_feed_cyc, TIMEOUT);
         end
      end
   end

   // Stub core: drives valid_out_i / r_i early in each cycle.
   initial begin
      forever begin
         @(posedge clk);
         #2;
         valid_out_i = 1'b0;
         r_i = '0;
         if (extra_pending) begin
            valid_out_i = 1'b1; r_i = 8'hEE; extra_pending = 1'b0;
         end else begin
            if (cd > 0) begin cd--; if (cd == 0) emitting = 1'b1; end
            if (emitting) begin
               if (e == 2 && gap_left > 0) gap_left--;
               else begin
                  valid_out_i = 1'b1; r_i = resp[e];
                  if (e == N-1) begin emitting = 1'b0; e = 0; extra_pending = extra; end
                  else e++;
               end
            end
         end
         if (valid_in_o) begin
            sfed++;
            if (sfed == N) begin
               sfed = 0;
               if (answer) begin cd = resp_delay; gap_left = gap_cfg; end
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no completion, expected finish before time limit");
      $fatal(1);
   end

   initial begin
      int s0, v0, d0, e0;
      logic [W-1:0] ra, rp, held;

      tick();
      check("reset_flags", W'({ready_o, busy_o, done_o, error_o, mi_start_o, valid_in_o}), 32'b100000);
      check("reset_words", W'({a_o, p_o}), 0);
      check("reset_result", result_o, 0);
      rst = 1'b0;
      tick();

      // Basic job: answer 5 cycles after the last fed word.
      set_resp(8'h11, 8'h22, 8'h33, 8'h44);
      resp_delay = 5; gap_cfg = 0; answer = 1'b1; extra = 1'b0;
      s0 = n_start; v0 = n_vin; d0 = n_done; e0 = n_error;
      start_job(32'hA1B2C3D4, 32'h0F1E2D3C, 1'b1);
      wait_count(1'b0, d0 + 1, 100);
      repeat (3) tick();
      check("t2_start_cycles", n_start - s0, 1);
      check("t2_vin_cycles", n_vin - v0, N);
      check("t2_done_count", n_done - d0, 1);
      check("t2_no_error", n_error - e0, 0);
      check("t2_result_hold", result_o, 32'h44332211);

      // Three idle cycles between result words 1 and 2.
      gap_cfg = 3;
      d0 = n_done; e0 = n_error;
      start_job(32'h55AA33CC, 32'h89ABCDEF, 1'b1);
      wait_count(1'b0, d0 + 1, 100);
      repeat (2) tick();
      check("t3_done_count", n_done - d0, 1);
      check("t3_no_error", n_error - e0, 0);
      check("t3_result", result_o, 32'h44332211);

      // Core never answers: timeout.
      gap_cfg = 0; answer = 1'b0;
      d0 = n_done;
      start_job(32'h01020304, 32'h05060708, 1'b0);
      wait_count(1'b1, n_error + 1, 100);
      check("t4_ready_after_error", W'({ready_o, busy_o}), 32'b10);
      check("t4_result_unchanged", result_o, 32'h44332211);
      check("t4_no_done", n_done - d0, 0);
      answer = 1'b1;

      // start_i held high across two jobs.
      set_resp(8'h5A, 8'hC3, 8'h0F, 8'h96);
      s0 = n_start; d0 = n_done;
      push_job(32'hDEADBEEF, 32'hCAFEF00D, 1'b1);
      push_job(32'hDEADBEEF, 32'hCAFEF00D, 1'b1);
      start_i = 1'b1; a_i = 32'hDEADBEEF; p_i = 32'hCAFEF00D;
      tick();
      wait_done_level(100);
      check("t5_ready_in_done", W'(ready_o), 1);
      tick();
      check("t5_b2b_start", W'(mi_start_o), 1);
      tick();
      wait_done_level(100);
      start_i = 1'b0;
      repeat (4) tick();
      check("t5_start_count", n_start - s0, 2);
      check("t5_done_count", n_done - d0, 2);

      // Reset during FEED word 2, then a fresh job.
      set_resp(8'h11, 8'h22, 8'h33, 8'h44);
      d0 = n_done; e0 = n_error;
      start_job(32'h13579BDF, 32'h2468ACE0, 1'b1);
      begin
         int t = 0;
         while (!(valid_in_o && mfed == 2) && t < 20) begin tick(); t++; end
      end
      check("t6_at_word2", W'(int'(valid_in_o && mfed == 2)), 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      feed_q.delete(); exp_q.delete();
      sfed = 0; mfed = 0; cd = 0; e = 0; gap_left = 0;
      emitting = 1'b0; extra_pending = 1'b0;
      check("t6_flags", W'({ready_o, busy_o, done_o, error_o, mi_start_o, valid_in_o}), 32'b100000);
      check("t6_words", W'({a_o, p_o}), 0);
      check("t6_result", result_o, 0);
      repeat (30) tick();
      check("t6_no_done", n_done - d0, 0);
      check("t6_no_error", n_error - e0, 0);
      start_job(32'h0BADF00D, 32'h7FFFFFFF, 1'b1);
      wait_count(1'b0, d0 + 1, 100);
      tick();
      check("t6_fresh_result", result_o, 32'h44332211);

      // Randomised jobs, some with a stray trailing valid word.
      for (int j = 0; j < 6; j++) begin
         for (int i = 0; i < N; i++) resp[i] = K'($urandom_range(0, 255));
         resp_delay = $urandom_range(1, 8);
         gap_cfg = $urandom_range(0, 3);
         extra = 1'($urandom_range(0, 1));
         ra = $urandom; rp = $urandom;
         held = expected_result();
         d0 = n_done;
         start_job(ra, rp, 1'b1);
         wait_count(1'b0, d0 + 1, 100);
         repeat (3) tick();
         check("rand_result_hold", result_o, held);
      end

      check("queues_drained", exp_q.size() + feed_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/mi_stream_ctrl.md
Name: mi_stream_ctrl

Overview:
- Sequencer that sits directly upstream and downstream of modular_inverse_optimize.
- Accepts full-width operands a and p (K*N bits each) and issues the core's mi_start pulse.
- Streams the operands word-serially, least-significant word first, to the core.
- Reassembles the core's N-word result stream into one K*N-bit result, and flags a timeout if the core never answers.

Parameters:
- K, 128, word width in bits (matches core K)
- N, 32, number of words per operand (matches core N)
- TIMEOUT, 2**20, max cycles in WAIT before the error exit

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- start_i  in  1  request; accepted only when ready_o=1
- a_i  in  K*N  operand a; sampled on the accept cycle
- p_i  in  K*N  modulus p; sampled on the accept cycle
- ready_o  out  1  high only in IDLE
- busy_o  out  1  high in every state except IDLE
- result_o  out  K*N  assembled inverse; holds its value until the next accept
- done_o  out  1  one-cycle pulse when result_o is valid
- error_o  out  1  one-cycle pulse on timeout
- mi_start_o  out  1  to core mi_start
- a_o  out  K  to core a
- p_o  out  K  to core p
- valid_in_o  out  1  to core valid_in
- r_i  in  K  from core r
- valid_out_i  in  1  from core valid_out

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - State goes to IDLE.
  - All outputs go to 0 except ready_o=1. This includes result_o, a_o, p_o, mi_start_o, valid_in_o, done_o and error_o.
  - Word and timeout counters clear; latched operands clear.
  - Reset mid-operation aborts with no done_o or error_o pulse. The core shares the reset domain.
- States: IDLE -> START -> FEED -> WAIT -> COLLECT -> IDLE.
- IDLE:
  - start_i=1 latches a_i and p_i into internal K*N registers and moves to START.
  - result_o is not cleared on accept.
- START:
  - mi_start_o=1 for exactly one cycle, then move to FEED.
- FEED:
  - Runs N consecutive cycles with valid_in_o=1.
  - On cycle i (i=0..N-1): a_o=a_lat[K*i +: K] and p_o=p_lat[K*i +: K].
  - After word N-1, move to WAIT; valid_in_o, a_o and p_o return to 0.
  - There are no gaps; the core has no backpressure.
- WAIT:
  - The timeout counter increments each cycle.
  - valid_out_i=1 moves to COLLECT, and that same cycle's r_i is captured as word 0.
  - If the counter reaches TIMEOUT-1 without valid_out_i, error_o pulses for one cycle, the state goes to IDLE and result_o is unchanged.
- COLLECT:
  - Each cycle with valid_out_i=1 stores r_i into result_o[K*j +: K], then j increments.
  - Cycles with valid_out_i=0 are tolerated: hold, no capture, no timeout.
  - When word N-1 is stored, done_o pulses in the next cycle and the state goes to IDLE (ready_o=1 in that same cycle).
- Word accumulation: result words are written in place as they arrive, so result_o is partially updated during COLLECT. It is guaranteed complete only when done_o=1.
- Ignored events:
  - start_i while busy is dropped; it is not queued.
  - valid_out_i outside WAIT/COLLECT is dropped.
  - Extra valid cycles after word N-1 are dropped.
- Back-to-back operation: start_i may be high in the done_o cycle and is accepted there, since ready_o=1. This gives a minimum of 1 idle cycle between jobs.
- Latency from accept to mi_start_o is 1 cycle. FEED ends N+1 cycles after accept.
- Counter widths: word counter $clog2(N) bits; timeout counter $clog2(TIMEOUT)+1 bits. All counters wrap-free by construction.

Decomposition:
- Package mi_pkg holds:
  - the state enum (IDLE, START, FEED, WAIT, COLLECT);
  - localparams for default K, N and TIMEOUT;
  - the function clog2_safe (returns 1 for N=1).
- One natural sub-module: mi_word_serdes. It is a K*N to K shifter for FEED and a K to K*N indexed writer for COLLECT, driven by the controller's word index and enable.
- The FSM and counters stay in the top module.

Test Plan:
1. Known-good vector with K=128, N=32, a and p set to the 4096-bit pair used in core bring-up, and the real core attached. Required response:
   - mi_start_o high exactly 1 cycle;
   - 32 valid_in_o cycles with a_o word0 = 128'h...233349;
   - done_o pulses once;
   - result_o*a mod p == 1 (checked by a reference model).
2. Stub core with N=4, K=8, answering 5 cycles after the last valid_in with r=8'h11, 8'h22, 8'h33, 8'h44 -> result_o=32'h44332211 and done_o on the cycle after the 4th word.
3. Stub core inserting a 3-cycle gap of valid_out_i=0 between words 1 and 2 -> same result_o=32'h44332211, done_o delayed by 3 cycles, error_o=0.
4. Stub core never raising valid_out_i, with TIMEOUT=16 -> error_o pulses on WAIT cycle 16, ready_o=1 next, result_o unchanged from test 3.
5. start_i held high continuously through a job -> exactly one mi_start_o per job; a second job begins in the done_o cycle.
6. rst=1 asserted during FEED word 2 -> the next cycle shows all outputs 0, ready_o=1, and no done_o or error_o pulse. A fresh start_i then completes normally.
